shift_serializer: RTL and testbench



---
 rtl/shift_serializer_pkg.sv | 9 +
 rtl/shift_serializer.sv | 84 ++++++++
 tb/tb_shift_serializer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_serializer_pkg.sv
// Shared types for the parallel-to-serial converter.
package shift_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/shift_serializer.sv
// Parallel-to-serial converter: loads an N-bit word over valid/ready and emits one bit per
// serial handshake, shifting left (MSB first) or right (LSB first).
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_last
);

    localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    ser_state_t    state_q, state_d;
    logic [N-1:0]  sr_q, sr_d, sr_shift;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_fire, bit_fire;

    generate
        if (MSB_FIRST) begin : g_shift_left
            assign sr_shift = sr_q << 1;
        end else begin : g_shift_right
            assign sr_shift = sr_q >> 1;
        end
    endgenerate

    assign in_fire  = in_valid && in_ready;
    assign bit_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // A load on the last-bit handshake takes priority, giving back-to-back words with no bubble.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (in_fire) begin
            sr_d    = in_data;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (bit_fire) begin
            if (out_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == SHIFT);
        out_bit   = MSB_FIRST ? sr_q[N-1] : sr_q[0];
        out_last  = out_valid && (cnt_q == CNT_LAST);
        in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);
    end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: MSB-first and LSB-first instances share stimulus and are checked
// against a bit-queue scoreboard every cycle.
module tb_shift_serializer;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] in_data;

    logic m_in_ready, m_out_valid, m_out_bit, m_out_last;
    logic l_in_ready, l_out_valid, l_out_bit, l_out_last;

    int checks = 0;
    int errors = 0;
    int bits_done = 0;

    bit           qm[$];
    bit           ql[$];
    logic [N-1:0] words[$];

    shift_serializer #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .in_data   (in_data),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .out_bit   (m_out_bit),
        .out_last  (m_out_last)
    );

    shift_serializer #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .in_data   (in_data),
        .out_valid (l_out_valid),
        .out_ready (out_ready),
        .out_bit   (l_out_bit),
        .out_last  (l_out_last)
    );

    always #5 clk = ~clk;

    // Expected {valid, bit, last, in_ready} from the scoreboard queue.
    function automatic logic [3:0] exp_vec(input bit lsb);
        int sz = qm.size();
        bit b  = 1'b0;
        if (sz > 0) b = lsb ? ql[0] : qm[0];
        return {sz > 0, b, sz == 1, (sz == 0) || (out_ready && sz == 1)};
    endfunction

    // Model update for the coming clock edge: pop an accepted bit, push an accepted word.
    task automatic advance();
        bit rdy = (qm.size() == 0) || (out_ready && qm.size() == 1);
        if (qm.size() > 0 && out_ready) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
            bits_done++;
        end
        if (in_valid && rdy) begin
            for (int i = N - 1; i >= 0; i--) qm.push_back(in_data[i]);
            for (int i = 0; i < N; i++) ql.push_back(in_data[i]);
            if (words.size() > 0) void'(words.pop_front());
        end
    endtask

    task automatic drive(input bit en, input bit ordy);
        @(negedge clk);
        in_valid  = en && (words.size() > 0);
        in_data   = (words.size() > 0) ? words[0] : '0;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] gm, gl;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        gm = {m_out_valid, m_out_bit, m_out_last, m_in_ready};
        gl = {l_out_valid, l_out_bit, l_out_last, l_in_ready};
        checks += 2;
        if (gm !== 4'b0001) begin errors++; $display("FAIL reset_msb: got %b want 0001", gm); end
        if (gl !== 4'b0001) begin errors++; $display("FAIL reset_lsb: got %b want 0001", gl); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] gm, gl, em, el;
        int base = bits_done;
        words.push_back(8'b1011_0010);
        for (int c = 0; c < 11; c++) begin
            drive(1'b1, 1'b1);
            gm = {m_out_valid, m_out_valid & m_out_bit, m_out_last, m_in_ready}; em = exp_vec(0);
            gl = {l_out_valid, l_out_valid & l_out_bit, l_out_last, l_in_ready}; el = exp_vec(1);
            checks += 2;
            if (gm !== em) begin errors++; $display("FAIL single_msb cyc %0d: got %b want %b", c, gm, em); end
            if (gl !== el) begin errors++; $display("FAIL single_lsb cyc %0d: got %b want %b", c, gl, el); end
            advance();
        end
        checks++;
        if (bits_done - base != 8) begin
            errors++; $display("FAIL single_count: got %0d bits want 8", bits_done - base);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] gm, gl, em, el;
        words.push_back(8'hA5);
        words.push_back(8'h3C);
        for (int c = 0; c < 19; c++) begin
            drive(1'b1, 1'b1);
            gm = {m_out_valid, m_out_valid & m_out_bit, m_out_last, m_in_ready}; em = exp_vec(0);
            gl = {l_out_valid, l_out_valid & l_out_bit, l_out_last, l_in_ready}; el = exp_vec(1);
            checks += 2;
            if (gm !== em) begin errors++; $display("FAIL b2b_msb cyc %0d: got %b want %b", c, gm, em); end
            if (gl !== el) begin errors++; $display("FAIL b2b_lsb cyc %0d: got %b want %b", c, gl, el); end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] gm, gl, em, el;
        int base  = bits_done;
        int stall = 0;
        bit ordy;
        words.push_back(8'hF0);
        for (int c = 0; c < 14; c++) begin
            ordy = !((bits_done - base == 2) && stall < 3);
            if (!ordy) stall++;
            drive(1'b1, ordy);
            gm = {m_out_valid, m_out_valid & m_out_bit, m_out_last, m_in_ready}; em = exp_vec(0);
            gl = {l_out_valid, l_out_valid & l_out_bit, l_out_last, l_in_ready}; el = exp_vec(1);
            checks += 2;
            if (gm !== em) begin errors++; $display("FAIL bp_msb cyc %0d: got %b want %b", c, gm, em); end
            if (gl !== el) begin errors++; $display("FAIL bp_lsb cyc %0d: got %b want %b", c, gl, el); end
            advance();
        end
        checks++;
        if (bits_done - base != 8) begin
            errors++; $display("FAIL bp_count: got %0d bits want 8", bits_done - base);
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] gm, gl, em, el;
        int base = bits_done;
        words.push_back(8'h00);
        words.push_back(8'hFF);
        for (int c = 0; c < 20; c++) begin
            // 8'hFF is offered from bit 3 of 8'h00 and held until accepted
            drive((words.size() == 2) || (bits_done - base >= 3), 1'b1);
            gm = {m_out_valid, m_out_valid & m_out_bit, m_out_last, m_in_ready}; em = exp_vec(0);
            gl = {l_out_valid, l_out_valid & l_out_bit, l_out_last, l_in_ready}; el = exp_vec(1);
            checks += 2;
            if (gm !== em) begin errors++; $display("FAIL busy_msb cyc %0d: got %b want %b", c, gm, em); end
            if (gl !== el) begin errors++; $display("FAIL busy_lsb cyc %0d: got %b want %b", c, gl, el); end
            advance();
        end
        checks++;
        if (bits_done - base != 16) begin
            errors++; $display("FAIL busy_count: got %0d bits want 16", bits_done - base);
        end
    endtask

    task automatic test_reset_midword();
        logic [3:0] gm, gl, em, el;
        int base = bits_done;
        int c    = 0;
        words.push_back(8'h81);
        while (bits_done - base < 4 && c < 12) begin
            drive(1'b1, 1'b1);
            gm = {m_out_valid, m_out_valid & m_out_bit, m_out_last, m_in_ready}; em = exp_vec(0);
            gl = {l_out_valid, l_out_valid & l_out_bit, l_out_last, l_in_ready}; el = exp_vec(1);
            checks += 2;
            if (gm !== em) begin errors++; $display("FAIL rstmid_msb cyc %0d: got %b want %b", c, gm, em); end
            if (gl !== el) begin errors++; $display("FAIL rstmid_lsb cyc %0d: got %b want %b", c, gl, el); end
            advance();
            c++;
        end
        checks++;
        if (bits_done - base != 4) begin
            errors++; $display("FAIL rstmid_reach: got %0d bits want 4", bits_done - base);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks += 2;
        if ({m_out_valid, m_out_last} !== 2'b00) begin
            errors++; $display("FAIL rstmid_drop_msb: got %b want 00", {m_out_valid, m_out_last});
        end
        if ({l_out_valid, l_out_last} !== 2'b00) begin
            errors++; $display("FAIL rstmid_drop_lsb: got %b want 00", {l_out_valid, l_out_last});
        end
        qm.delete();
        ql.delete();
        @(negedge clk);
        rst = 1'b0;
        words.push_back(8'h81);
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, 1'b1);
            gm = {m_out_valid, m_out_valid & m_out_bit, m_out_last, m_in_ready}; em = exp_vec(0);
            gl = {l_out_valid, l_out_valid & l_out_bit, l_out_last, l_in_ready}; el = exp_vec(1);
            checks += 2;
            if (gm !== em) begin errors++; $display("FAIL rstpost_msb cyc %0d: got %b want %b", k, gm, em); end
            if (gl !== el) begin errors++; $display("FAIL rstpost_lsb cyc %0d: got %b want %b", k, gl, el); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_busy_ignore();
        test_reset_midword();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
